bram_mac_sequencer: RTL
=======================

BRAM_MAC_SEQUENCER -- requirements
Module: bram_mac_sequencer

Interface
REQ-001 Parameter ADDR_W, default 10, BRAM address width (1024 entries).
REQ-002 Parameter DATA_W, default 8, BRAM word and multiplier operand width.
REQ-003 Parameter ACC_W, default 32, accumulator width.
REQ-004 clk  in  1  single clock; all logic SHALL be on its rising edge.
REQ-005 reset  in  1  reset, synchronous, active-low.
REQ-006 wr_en  in  1  host BRAM write strobe.
REQ-007 wr_addr  in  ADDR_W  host write address.
REQ-008 wr_data  in  DATA_W  host write data.
REQ-009 start  in  1  single-cycle job launch.
REQ-010 base_a  in  ADDR_W  first operand-A address.
REQ-011 base_b  in  ADDR_W  first operand-B address.
REQ-012 len  in  ADDR_W  number of A*B pairs.
REQ-013 busy  out  1  job in progress.
REQ-014 done  out  1  one-cycle completion pulse.
REQ-015 wr_err  out  1  one-cycle pulse: write rejected.
REQ-016 acc_out  out  ACC_W  dot-product result.

Function
REQ-017 The block SHALL own one 2^ADDR_W x DATA_W BRAM: one synchronous write port, one read port with one-cycle registered read latency.
REQ-018 FSM states SHALL be IDLE, RD_A, RD_B, MUL, ACC, DONE.
REQ-019 IDLE: start=1 SHALL latch base_a, base_b and len, clear acc_out, and go to DONE if len==0, else to RD_A.
REQ-020 RD_A issues the A read; RD_B captures A and issues the B read; MUL captures B and registers the DATA_W x DATA_W product; ACC adds the product to the accumulator, increments both addresses, decrements the count, then goes to DONE if the count reaches 0, else to RD_A.
REQ-021 DONE SHALL assert done for exactly one cycle and then return to IDLE.
REQ-022 busy SHALL be 1 in every state except IDLE.
REQ-023 Timing: start sampled in cycle 0 puts done in cycle 4*len+1, with acc_out valid from that cycle; len==0 gives done in cycle 1 with acc_out=0.
REQ-024 acc_out SHALL hold its value from DONE until the next accepted start.
REQ-025 Address increments SHALL wrap modulo 2^ADDR_W.
REQ-026 Accumulation SHALL wrap modulo 2^ACC_W.
REQ-027 start while busy=1 SHALL be ignored, with no effect on the running job.
REQ-028 wr_en while busy=1 SHALL not write and SHALL pulse wr_err in the next cycle.
REQ-029 wr_en while busy=0 SHALL write in that cycle.
REQ-030 wr_en and start in the same IDLE cycle SHALL both be accepted; the written word SHALL be visible to the job.
REQ-031 Overlapping base_a and base_b ranges SHALL be legal.

Reset
REQ-032 With reset=0 at a clock edge: FSM to IDLE; busy, done, wr_err, acc_out, counters and address registers to 0.
REQ-033 Reset mid-job SHALL abort the job without a done pulse.
REQ-034 BRAM contents SHALL NOT be reset.

Configuration
REQ-035 Macro BRAM_MAC_SIGNED_EN defined: operands are two's-complement and the product is sign-extended to ACC_W.
REQ-036 Macro BRAM_MAC_SIGNED_EN undefined: operands are unsigned and the product is zero-extended to ACC_W.

Structure
REQ-037 Package bram_mac_pkg SHALL hold the FSM state enum typedef and the ADDR_W, DATA_W and ACC_W default constants.
REQ-038 The BRAM SHALL be a sub-module bram_mac_ram, written as inferable 1024x8 block RAM.
REQ-039 The multiplier SHALL be inferable to a DSP block.

Verification
REQ-040 Write A[0..3]={1,2,3,4} and B[16..19]={5,6,7,8}; start base_a=0, base_b=16, len=4 -> done in cycle 17, acc_out=70, busy high cycles 1-17.
REQ-041 Start with len=0 -> done in cycle 1, acc_out=0, no BRAM reads.
REQ-042 Pulse wr_en at cycle 3 of a running job -> wr_err in cycle 4; BRAM unchanged; acc_out unaffected.
REQ-043 A[1022..1023]={2,3}, A[0]=4, B[100..102]={1,1,1}; start base_a=1022, base_b=100, len=3 -> acc_out=9 (address wrap).
REQ-044 A[0]=0xFF, B[1]=0x02, len=1 -> acc_out=0xFFFFFFFE with BRAM_MAC_SIGNED_EN, 0x000001FE without.
REQ-045 Drive reset=0 in cycle 6 of the REQ-040 job -> no done pulse; all outputs 0; a new start then gives acc_out=70.

Source files
------------

// File: rtl/bram_mac_pkg.sv
// Shared FSM state type and default widths for the BRAM dot-product sequencer.
package bram_mac_pkg;

    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 8;
    localparam int ACC_W_DEF  = 32;

    typedef enum logic [2:0] {
        IDLE,
        RD_A,
        RD_B,
        MUL,
        ACC,
        DONE
    } state_t;

endpackage

// File: rtl/bram_mac_ram.sv
// Simple dual-port block RAM: synchronous write, registered read (1 cycle latency).
// No reset on storage or read register so the array maps onto a BRAM primitive.
module bram_mac_ram #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/bram_mac_sequencer.sv
// Dot product over BRAM-resident vectors A/B; BRAM_MAC_SIGNED_EN selects signed operands.
// Latency 4*len+1 cycles from start to done; start and host writes are refused while busy.
module bram_mac_sequencer
    import bram_mac_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int ACC_W  = ACC_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_a,
    input  logic [ADDR_W-1:0] base_b,
    input  logic [ADDR_W-1:0] len,
    output logic              busy,
    output logic              done,
    output logic              wr_err,
    output logic [ACC_W-1:0]  acc_out
);

    localparam int PROD_W = 2 * DATA_W;
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] addr_a, addr_b, cnt;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_en, ram_we;
    logic [DATA_W-1:0] rd_data, opnd_a;
    logic [PROD_W-1:0] mul, prod;
    logic [ACC_W-1:0]  prod_ext, acc;

    // Host writes only land while idle, which also covers the start cycle.
    assign ram_we  = wr_en && (state == IDLE);
    assign rd_en   = (state == RD_A) || (state == RD_B);
    assign rd_addr = (state == RD_B) ? addr_b : addr_a;
    assign acc_out = acc;

`ifdef BRAM_MAC_SIGNED_EN
    assign mul      = PROD_W'($signed(opnd_a)) * PROD_W'($signed(rd_data));
    assign prod_ext = ACC_W'($signed(prod));
`else
    assign mul      = PROD_W'(opnd_a) * PROD_W'(rd_data);
    assign prod_ext = ACC_W'(prod);
`endif

    bram_mac_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk     (clk),
        .we      (ram_we),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nxt = (len == '0) ? DONE : RD_A;
                end
            end
            RD_A:    state_nxt = RD_B;
            RD_B:    state_nxt = MUL;
            MUL:     state_nxt = ACC;
            ACC:     state_nxt = (cnt == ADDR_ONE) ? DONE : RD_A;
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // RD_B sees the A word on rd_data, MUL sees the B word.
    always_ff @(posedge clk) begin
        if (!reset) begin
            addr_a <= '0;
            addr_b <= '0;
            cnt    <= '0;
            opnd_a <= '0;
            prod   <= '0;
            acc    <= '0;
            wr_err <= 1'b0;
        end else begin
            wr_err <= wr_en && busy;
            case (state)
                IDLE: begin
                    if (start) begin
                        addr_a <= base_a;
                        addr_b <= base_b;
                        cnt    <= len;
                        acc    <= '0;
                    end
                end
                RD_B: opnd_a <= rd_data;
                MUL:  prod   <= mul;
                ACC: begin
                    acc    <= acc + prod_ext;
                    addr_a <= addr_a + ADDR_ONE;
                    addr_b <= addr_b + ADDR_ONE;
                    cnt    <= cnt - ADDR_ONE;
                end
                default: ;
            endcase
        end
    end

endmodule
